// File: rtl/ucsbece154b_bp_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// RISC-V control-flow opcodes and default geometry.
package ucsbece154b_bp_pkg;

  localparam int DEFAULT_NUM_BTB_ENTRIES = 32;
  localparam int DEFAULT_NUM_GHR_BITS    = 5;

  typedef enum logic [1:0] {
    PHT_SNT = 2'b00,
    PHT_WNT = 2'b01,
    PHT_WT  = 2'b10,
    PHT_ST  = 2'b11
  } pht_cnt_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != PHT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != PHT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped branch target buffer: combinational lookup from the fetch PC,
// one write port from execute. Reads see the array contents before any same-edge write.
module ucsbece154b_btb
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_ENTRIES = DEFAULT_NUM_BTB_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_rd,
  output logic        hit,
  output logic        jump,
  output logic [31:0] target,
  input  logic        we,
  input  logic [31:0] pc_wr,
  input  logic [31:0] target_wr,
  input  logic        jump_wr
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]       tag_q    [NUM_ENTRIES];
  logic [31:0]            target_q [NUM_ENTRIES];

  logic [IDX_W-1:0] idx_rd, idx_wr;
  logic [TAG_W-1:0] tag_rd, tag_wr;

  assign idx_rd = pc_rd[IDX_W+1:2];
  assign tag_rd = pc_rd[31:IDX_W+2];
  assign idx_wr = pc_wr[IDX_W+1:2];
  assign tag_wr = pc_wr[31:IDX_W+2];

  // Byte-offset bits never participate in lookup.
  logic unused_ok;
  assign unused_ok = &{1'b0, pc_rd[1:0], pc_wr[1:0]};

  assign hit    = valid_q[idx_rd] && (tag_q[idx_rd] == tag_rd);
  assign jump   = jump_q[idx_rd];
  assign target = hit ? target_q[idx_rd] : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[idx_wr] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      tag_q[idx_wr]    <= tag_wr;
      target_q[idx_wr] <= target_wr;
      jump_q[idx_wr]   <= jump_wr;
    end
  end

endmodule

// File: rtl/ucsbece154b_gshare_predictor.sv
// Gshare predictor: BTB + global-history-indexed PHT with F->D->E prediction pipe.
// Optional performance counters are built only when UCSBECE154B_BP_STATS_EN is defined.
module ucsbece154b_gshare_predictor
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = DEFAULT_NUM_BTB_ENTRIES,
  parameter int NUM_GHR_BITS    = DEFAULT_NUM_GHR_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        FlushE_i,
  input  logic [31:0] PCE_i,
  input  logic [31:0] PCTargetE_i,
  input  logic        BranchE_i,
  input  logic        JumpE_i,
  input  logic        TakenE_i,
  output logic        BranchTakenF_o,
  output logic [31:0] BTBtargetF_o,
  output logic        BranchTakenE_o,
  output logic [31:0] BranchCount_o,
  output logic [31:0] MispredCount_o
);

  localparam int PHT_DEPTH = 1 << NUM_GHR_BITS;

  logic [NUM_GHR_BITS-1:0] ghr_q;
  logic [NUM_GHR_BITS-1:0] idx_f, idx_d_q, idx_e_q;
  logic [1:0]              pht_q [PHT_DEPTH];
  logic                    pred_f, pred_d_q, pred_e_q;
  logic                    hit_f, jump_f;
  logic [31:0]             target_f;
  logic                    btb_we, pht_upd;

  // A jal/jalr flagged as a branch too is treated purely as a jump.
  assign btb_we  = BranchE_i | JumpE_i;
  assign pht_upd = BranchE_i & ~JumpE_i;

  ucsbece154b_btb #(
    .NUM_ENTRIES(NUM_BTB_ENTRIES)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .pc_rd    (PCF_i),
    .hit      (hit_f),
    .jump     (jump_f),
    .target   (target_f),
    .we       (btb_we),
    .pc_wr    (PCE_i),
    .target_wr(PCTargetE_i),
    .jump_wr  (JumpE_i)
  );

  assign idx_f  = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  assign pred_f = hit_f & (jump_f | pht_q[idx_f][1]);

  assign BranchTakenF_o = pred_f;
  assign BTBtargetF_o   = target_f;
  assign BranchTakenE_o = pred_e_q;

  // Flush wins over stall on the decode register.
  always_ff @(posedge clk) begin
    if (reset || FlushD_i) begin
      pred_d_q <= 1'b0;
      idx_d_q  <= '0;
    end else if (!StallD_i) begin
      pred_d_q <= pred_f;
      idx_d_q  <= idx_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE_i) begin
      pred_e_q <= 1'b0;
      idx_e_q  <= '0;
    end else begin
      pred_e_q <= pred_d_q;
      idx_e_q  <= idx_d_q;
    end
  end

  // The PHT is trained at the index the prediction was made with, not a recomputed one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= PHT_WNT;
      end
    end else if (pht_upd) begin
      pht_q[idx_e_q] <= pht_next(pht_q[idx_e_q], TakenE_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (pht_upd) begin
      ghr_q <= {ghr_q[NUM_GHR_BITS-2:0], TakenE_i};
    end
  end

`ifdef UCSBECE154B_BP_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (BranchE_i) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (pred_e_q != TakenE_i) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign BranchCount_o  = branch_cnt_q;
  assign MispredCount_o = mispred_cnt_q;
`else
  assign BranchCount_o  = 32'd0;
  assign MispredCount_o = 32'd0;
`endif

endmodule

// File: tb/tb_ucsbece154b_gshare_predictor.sv
// Self-checking bench for the gshare predictor: directed scenarios plus random
// traffic compared every cycle against an array-based reference model.
module tb_ucsbece154b_gshare_predictor;

  localparam int NB    = 32;
  localparam int NG    = 5;
  localparam int PHT_N = 1 << NG;
  localparam int IDXB  = $clog2(NB);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] pcf, pce, tgt;
  logic        stall_d, flush_d, flush_e, br, jmp, tk;
  logic        taken_f, taken_e;
  logic [31:0] target_f, bcount, mcount;

  ucsbece154b_gshare_predictor #(
    .NUM_BTB_ENTRIES(NB),
    .NUM_GHR_BITS   (NG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PCF_i         (pcf),
    .StallD_i      (stall_d),
    .FlushD_i      (flush_d),
    .FlushE_i      (flush_e),
    .PCE_i         (pce),
    .PCTargetE_i   (tgt),
    .BranchE_i     (br),
    .JumpE_i       (jmp),
    .TakenE_i      (tk),
    .BranchTakenF_o(taken_f),
    .BTBtargetF_o  (target_f),
    .BranchTakenE_o(taken_e),
    .BranchCount_o (bcount),
    .MispredCount_o(mcount)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_live = 0;
  bit          m_valid [NB];
  int unsigned m_tag   [NB];
  int unsigned m_tgt   [NB];
  bit          m_j     [NB];
  int          m_pht   [PHT_N];
  int          m_ghr;
  bit          m_d_pred, m_e_pred;
  int          m_d_idx, m_e_idx;
  int unsigned m_bcnt, m_mcnt;
  bit          stats_on;

  function automatic int btb_idx(input int unsigned pc);
    return (pc >> 2) % NB;
  endfunction

  function automatic int unsigned btb_tag(input int unsigned pc);
    return pc >> (2 + IDXB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_valid[i] = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    m_ghr = 0; m_d_pred = 0; m_e_pred = 0; m_d_idx = 0; m_e_idx = 0;
    m_bcnt = 0; m_mcnt = 0;
    m_live = 1;
  endtask

  // One clock: compare all outputs mid-cycle, advance the model, cross the edge.
  task automatic tick();
    int  bi, pi, old_e_idx;
    bit  hit, e_taken_f, old_d_pred, old_e_pred;
    int  old_d_idx;
    @(negedge clk);
    bi  = btb_idx(pcf);
    hit = m_valid[bi] && (m_tag[bi] == btb_tag(pcf));
    pi  = ((pcf >> 2) % PHT_N) ^ m_ghr;
    e_taken_f = hit && (m_j[bi] || m_pht[pi] >= 2);
    if (m_live) begin
      exp_q.push_back({31'd0, e_taken_f});
      exp_q.push_back(hit ? m_tgt[bi] : 32'd0);
      exp_q.push_back({31'd0, m_e_pred});
      exp_q.push_back(stats_on ? m_bcnt : 32'd0);
      exp_q.push_back(stats_on ? m_mcnt : 32'd0);
      check_val("taken_f",  {31'd0, taken_f}, exp_q.pop_front());
      check_val("target_f", target_f,         exp_q.pop_front());
      check_val("taken_e",  {31'd0, taken_e}, exp_q.pop_front());
      check_val("bcount",   bcount,           exp_q.pop_front());
      check_val("mcount",   mcount,           exp_q.pop_front());
    end
    if (reset) begin
      model_reset();
    end else begin
      old_d_pred = m_d_pred; old_d_idx = m_d_idx;
      old_e_pred = m_e_pred; old_e_idx = m_e_idx;
      m_e_pred = flush_e ? 1'b0 : old_d_pred;
      m_e_idx  = flush_e ? 0 : old_d_idx;
      if (flush_d) begin
        m_d_pred = 0; m_d_idx = 0;
      end else if (!stall_d) begin
        m_d_pred = e_taken_f; m_d_idx = pi;
      end
      if (br || jmp) begin
        m_valid[btb_idx(pce)] = 1;
        m_tag[btb_idx(pce)]   = btb_tag(pce);
        m_tgt[btb_idx(pce)]   = pce == pce ? tgt : tgt;
        m_j[btb_idx(pce)]     = jmp;
      end
      if (br && !jmp) begin
        if (tk) m_pht[old_e_idx] = (m_pht[old_e_idx] == 3) ? 3 : m_pht[old_e_idx] + 1;
        else    m_pht[old_e_idx] = (m_pht[old_e_idx] == 0) ? 0 : m_pht[old_e_idx] - 1;
        m_ghr = ((m_ghr << 1) | int'(tk)) % PHT_N;
      end
      if (br) begin
        m_bcnt++;
        if (old_e_pred != tk) m_mcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic [31:0] a_pcf, input logic a_stall, input logic a_fd,
                        input logic a_fe, input logic [31:0] a_pce, input logic [31:0] a_tgt,
                        input logic a_br, input logic a_jmp, input logic a_tk);
    pcf = a_pcf; stall_d = a_stall; flush_d = a_fd; flush_e = a_fe;
    pce = a_pce; tgt = a_tgt; br = a_br; jmp = a_jmp; tk = a_tk;
  endtask

  task automatic idle(input logic [31:0] a_pcf);
    set_in(a_pcf, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(32'h10);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned r;
`ifdef UCSBECE154B_BP_STATS_EN
    stats_on = 1;
`else
    stats_on = 0;
`endif
    do_reset();

    // Cold predictor: no hit, nothing in flight.
    idle(32'h10);
    #1;
    check_val("rst_taken_f",  {31'd0, taken_f}, 32'd0);
    check_val("rst_target_f", target_f,         32'd0);
    check_val("rst_taken_e",  {31'd0, taken_e}, 32'd0);
    tick();

    // jal learned in one resolve; predicted taken to its target next cycle.
    set_in(32'h10, 0, 0, 0, 32'h20, 32'h80, 0, 1, 1);
    tick();
    idle(32'h20);
    #1;
    check_val("jal_taken_f",  {31'd0, taken_f}, 32'd1);
    check_val("jal_target_f", target_f,         32'h80);
    tick();

    // Repeated taken branch at 0x40 drives its counter to saturation.
    for (int i = 0; i < 4; i++) begin
      set_in(32'h40, 0, 0, 0, 32'h40, 32'h400, 1, 0, 1);
      tick();
    end
    idle(32'h40);
    tick();

    // Same-cycle fetch and first write of 0x60 sees the old (empty) entry.
    set_in(32'h60, 0, 0, 0, 32'h60, 32'h600, 0, 1, 1);
    #1;
    check_val("bypass_old", {31'd0, taken_f}, 32'd0);
    tick();
    idle(32'h60);
    #1;
    check_val("bypass_new", {31'd0, taken_f}, 32'd1);
    tick();
    set_in(32'h64, 0, 0, 0, 32'h64, 32'h640, 1, 0, 1);
    tick();
    idle(32'h64);
    tick();

    // Flush of decode (with stall also high) kills the prediction.
    idle(32'h20);
    tick();
    set_in(32'h20, 1, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    tick();
    idle(32'h10);
    tick();
    idle(32'h10);
    #1;
    check_val("flush_d_kill", {31'd0, taken_e}, 32'd0);
    tick();

    // Two-cycle decode stall keeps the prediction alive into execute.
    idle(32'h20);
    tick();
    set_in(32'h10, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    tick();
    set_in(32'h10, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    #1;
    check_val("stall_e0", {31'd0, taken_e}, 32'd1);
    tick();
    idle(32'h10);
    #1;
    check_val("stall_e1", {31'd0, taken_e}, 32'd1);
    tick();

    // Ten branch resolves, exactly three mispredicted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(32'h10, 0, 0, 0, 32'h100, 32'h200, 1, 0, m_e_pred ^ (i < 3));
      tick();
    end
    idle(32'h10);
    #1;
    check_val("stats_branch", bcount, stats_on ? 32'd10 : 32'd0);
    check_val("stats_mispr",  mcount, stats_on ? 32'd3 : 32'd0);
    tick();

    // Random traffic over a small aliasing PC pool.
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 299) == 0);
      pcf     = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 15) << 2);
      pce     = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 15) << 2);
      tgt     = $urandom & 32'hFFFF_FFFC;
      stall_d = ($urandom_range(0, 7) == 0);
      flush_d = ($urandom_range(0, 9) == 0);
      flush_e = ($urandom_range(0, 9) == 0);
      tk      = $urandom_range(0, 1);
      r       = $urandom_range(0, 9);
      br      = (r <= 4) || (r == 7);
      jmp     = (r == 5) || (r == 6) || (r == 7);
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_gshare_predictor.md
UCSBECE154B_GSHARE_PREDICTOR -- requirements
Module: ucsbece154b_gshare_predictor

Interface
REQ-001 Parameter NUM_BTB_ENTRIES, 32, BTB depth; power of two, at least 4.
REQ-002 Parameter NUM_GHR_BITS, 5, global history length; PHT depth is 2^NUM_GHR_BITS.
REQ-003 clk  in  1  single clock; all state updates on the posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCF_i  in  32  fetch-stage PC being predicted.
REQ-006 StallD_i / FlushD_i  in  1 each  decode pipeline-register control from the hazard unit.
REQ-007 FlushE_i  in  1  execute pipeline-register control.
REQ-008 PCE_i / PCTargetE_i  in  32 each  resolving instruction's PC and its computed target.
REQ-009 BranchE_i / JumpE_i / TakenE_i  in  1 each  execute-stage instruction is a conditional branch, is jal/jalr, and its actual taken outcome.
REQ-010 BranchTakenF_o  out  1  predicted redirect for PCF_i.
REQ-011 BTBtargetF_o  out  32  predicted target for PCF_i.
REQ-012 BranchTakenE_o  out  1  prediction made for the instruction now in execute.
REQ-013 BranchCount_o / MispredCount_o  out  32 each  performance counters (see Configuration).

Function
REQ-014 BTB SHALL be direct-mapped: index PC[log2(NUM_BTB_ENTRIES)+1:2], tag the remaining upper PC bits; entry fields are valid, tag, target[31:0] and J (jump).
REQ-015 PHT SHALL hold 2-bit saturating counters (00 SNT, 01 WNT, 10 WT, 11 ST); index = PC[NUM_GHR_BITS+1:2] XOR GHR.
REQ-016 Prediction SHALL be combinational from PCF_i: BranchTakenF_o = hit & (J | PHT[idxF][1]); BTBtargetF_o = entry target on hit, else 0.
REQ-017 idxF and BranchTakenF_o SHALL be piped F->D->E; StallD_i holds the D register; FlushD_i / FlushE_i clear the D / E register to 0; flush has priority over stall.
REQ-018 BranchTakenE_o SHALL equal the E-stage copy of the piped prediction.
REQ-019 When BranchE_i|JumpE_i, the BTB entry at PCE_i SHALL be written on the next edge: valid=1, tag, target=PCTargetE_i, J=JumpE_i.
REQ-020 When BranchE_i, PHT[idxE] SHALL increment if TakenE_i, else decrement, saturating at 11 and 00.
REQ-021 When BranchE_i, GHR <= {GHR[NUM_GHR_BITS-2:0], TakenE_i}; jumps and non-branches leave GHR unchanged.
REQ-022 A same-cycle fetch read and execute write to the same BTB/PHT entry SHALL return the pre-write contents.
REQ-023 BranchE_i and JumpE_i both high SHALL be treated as a jump (no PHT/GHR update).

Reset
REQ-024 On reset: all BTB valid bits 0, all PHT counters 01, GHR 0, D/E pipe registers 0, counters 0; hence BranchTakenF_o=0, BTBtargetF_o=0 and BranchTakenE_o=0 in the cycle after reset.
REQ-025 Reset asserted mid-operation SHALL discard all learned state and any in-flight update in the same cycle.

Configuration
REQ-026 With UCSBECE154B_BP_STATS_EN defined: BranchCount_o increments on every cycle with BranchE_i=1; MispredCount_o increments when BranchE_i & (BranchTakenE_o != TakenE_i); both wrap modulo 2^32.
REQ-027 Without UCSBECE154B_BP_STATS_EN, no counter registers are built and both outputs SHALL be tied to 0.

Structure
REQ-028 Counter encodings, RISC-V branch/jal/jalr opcode constants and default parameter values SHALL live in shared package ucsbece154b_bp_pkg.
REQ-029 The BTB array with its tag compare SHALL be sub-module ucsbece154b_btb; PHT, GHR, pipe registers and stats stay in the top module.

Verification
REQ-030 Reset, then PCF_i=0x00000010 -> BranchTakenF_o=0 and BTBtargetF_o=0.
REQ-031 Resolve jal at PCE_i=0x20 with PCTargetE_i=0x80; next cycle PCF_i=0x20 -> BranchTakenF_o=1, BTBtargetF_o=0x80, and GHR is unchanged.
REQ-032 Resolve branch at 0x40 taken three times -> that counter saturates at 11 and GHR=00111; a fourth taken resolve leaves the counter at 11.
REQ-033 Same cycle: PCF_i=PCE_i=0x60 and a first write to that entry -> BranchTakenF_o=0 that cycle and 1 the next cycle (at the updated GHR index).
REQ-034 Predict taken at F, assert FlushD_i the next cycle -> BranchTakenE_o=0 two cycles later; with StallD_i held two cycles, the prediction reaches E intact.
REQ-035 With STATS_EN: 10 branch resolves, 3 with BranchTakenE_o != TakenE_i -> BranchCount_o=10 and MispredCount_o=3; without STATS_EN both stay 0.
